rv3n_muldiv_arbiter: RTL and testbench

//  Shares one rv3n_func_muldiv unit between NREQ issue lanes. Each cycle, round-robin selects
//  one lane's request and drives it into muldiv when the unit is not busy. Records the owner of

---
 rtl/rv3n_muldiv_arbiter_pkg.sv | 25 ++
 rtl/rv3n_muldiv_arbiter_owner_fifo.sv | 104 ++++++++++
 rtl/rv3n_muldiv_arbiter.sv | 156 +++++++++++++++
 tb/tb_rv3n_muldiv_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv3n_muldiv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rv3n_muldiv_arbiter_pkg
// Shared constants and types for the muldiv arbiter and its owner FIFO.
//   XLEN_DEF : default datapath width
//   PARA_W   : width of the muldiv op parameter field
//   IMM_W    : width of the muldiv immediate field
//   idx_w()  : index width for N items, never less than one bit
//   md_ctl_t : control part of a muldiv request (para + imm)
// -----------------------------------------------------------------------------
package rv3n_muldiv_arbiter_pkg;

   localparam int XLEN_DEF = 32;
   localparam int PARA_W   = 8;
   localparam int IMM_W    = 13;

   typedef struct packed {
      logic [PARA_W-1:0] para;
      logic [IMM_W-1:0]  imm;
   } md_ctl_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rv3n_muldiv_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// rv3n_owner_fifo
// Tracks which lane owns each muldiv op in flight, in issue order. Each entry
// carries the owning lane id and a discard bit; a flush marks every entry so
// that its result is dropped when it pops.
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-low
//   push_i         record a new in-flight op for lane push_id_i
//   push_id_i      owning lane of the op being pushed
//   pop_i          oldest op has completed
//   flush_mark_i   mark all current entries as discarded
//   head_id_o      owner lane of the oldest entry
//   head_discard_o discard bit of the oldest entry
//   count_o        number of valid entries
//   empty_o        no entries
//   full_o         DEPTH entries
// -----------------------------------------------------------------------------
module rv3n_owner_fifo
   import rv3n_muldiv_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int IDW   = 1,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           push_i,
   input  logic [IDW-1:0] push_id_i,
   input  logic           pop_i,
   input  logic           flush_mark_i,
   output logic [IDW-1:0] head_id_o,
   output logic           head_discard_o,
   output logic [CW-1:0]  count_o,
   output logic           empty_o,
   output logic           full_o
);

   localparam int PW = idx_w(DEPTH);

   logic [IDW-1:0]   id_q [DEPTH];
   logic [DEPTH-1:0] disc_q, disc_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      else return p + 1'b1;
   endfunction

   assign empty_o        = (cnt_q == '0);
   assign full_o         = (cnt_q == CW'(DEPTH));
   assign count_o        = cnt_q;
   assign head_id_o      = id_q[rd_q];
   assign head_discard_o = disc_q[rd_q];

   // Guard against misuse: no pop from empty, no push into a full FIFO
   // unless the same cycle frees a slot.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      disc_d = disc_q;
      // Marking unused slots too is harmless: a push rewrites the bit.
      if (flush_mark_i) disc_d = '1;
      if (push_ok) begin
         disc_d[wr_q] = 1'b0;
         wr_d         = ptr_inc(wr_q);
      end
      if (pop_ok) rd_d = ptr_inc(rd_q);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         disc_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         disc_q <= disc_d;
      end
   end

   // Owner ids are only meaningful while counted, so they need no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) id_q[wr_q] <= push_id_i;
   end

endmodule

// File: rtl/rv3n_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// rv3n_muldiv_arbiter
// Shares one muldiv unit between NREQ issue lanes. A round-robin pick chooses
// one requesting lane per cycle and forwards its request to muldiv with zero
// latency; the owner FIFO remembers who issued each op so that results are
// routed back to the right lane. A flush drops results still in flight.
// Ports:
//   clk_i, rst_i              clock, synchronous active-low reset
//   flush_i                   discard in-flight results, block grants
//   lane_req_valid_i/para_i/imm_i/pc_i/op0_i/op1_i   per-lane requests
//   lane_req_grant_o          one-hot grant
//   lane_ack_valid_o/data_o   result routed to owning lane
//   md_req_*_o                request into muldiv
//   md_ack_valid_i/data_i/busy_i  muldiv response and busy
//   arb_err_o                 sticky: result arrived with nothing in flight
// -----------------------------------------------------------------------------
module rv3n_muldiv_arbiter
   import rv3n_muldiv_arbiter_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int OWN_DEPTH = 2,
   parameter int XLEN      = XLEN_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic [NREQ-1:0]        lane_req_valid_i,
   input  logic [NREQ*PARA_W-1:0] lane_req_para_i,
   input  logic [NREQ*IMM_W-1:0]  lane_req_imm_i,
   input  logic [NREQ*XLEN-1:0]   lane_req_pc_i,
   input  logic [NREQ*XLEN-1:0]   lane_req_op0_i,
   input  logic [NREQ*XLEN-1:0]   lane_req_op1_i,
   output logic [NREQ-1:0]        lane_req_grant_o,
   output logic [NREQ-1:0]        lane_ack_valid_o,
   output logic [XLEN-1:0]        lane_ack_data_o,
   output logic                   md_req_valid_o,
   output logic [PARA_W-1:0]      md_req_para_o,
   output logic [IMM_W-1:0]       md_req_imm_o,
   output logic [XLEN-1:0]        md_req_pc_o,
   output logic [XLEN-1:0]        md_req_op0_o,
   output logic [XLEN-1:0]        md_req_op1_o,
   input  logic                   md_ack_valid_i,
   input  logic [XLEN-1:0]        md_ack_data_i,
   input  logic                   md_ack_busy_i,
   output logic                   arb_err_o
);

   localparam int LANE_ID_W = idx_w(NREQ);
   localparam int CW        = $clog2(OWN_DEPTH + 1);

   logic [LANE_ID_W-1:0] rr_q, rr_d;
   logic                 arb_err_q, arb_err_d;

   logic                 fifo_empty, fifo_full;
   logic [LANE_ID_W-1:0] head_id;
   logic                 head_discard;
   logic [CW-1:0]        fifo_count;

   logic                 pop;
   logic                 can_issue;
   logic                 win_found;
   logic [LANE_ID_W-1:0] win_id;
   logic                 grant_any;
   logic                 ack_ok;
   md_ctl_t              sel_ctl;

   // First requesting lane at or above ptr, wrapping to lane 0.
   // Returns {found, lane index}.
   function automatic logic [LANE_ID_W:0] rr_pick(input logic [NREQ-1:0]      v,
                                                  input logic [LANE_ID_W-1:0] ptr);
      logic                 found;
      logic [LANE_ID_W-1:0] idx;
      int                   c;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         c = (int'(ptr) + k) % NREQ;
         if (!found && v[c]) begin
            found = 1'b1;
            idx   = LANE_ID_W'(c);
         end
      end
      return {found, idx};
   endfunction

   rv3n_owner_fifo #(
      .DEPTH (OWN_DEPTH),
      .IDW   (LANE_ID_W),
      .CW    (CW)
   ) u_fifo (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .push_i         (grant_any),
      .push_id_i      (win_id),
      .pop_i          (pop),
      .flush_mark_i   (flush_i),
      .head_id_o      (head_id),
      .head_discard_o (head_discard),
      .count_o        (fifo_count),
      .empty_o        (fifo_empty),
      .full_o         (fifo_full)
   );

   // A completing op frees its slot in the same cycle, so a full FIFO can
   // still accept a grant alongside a pop.
   assign pop       = md_ack_valid_i & ~fifo_empty;
   assign can_issue = ~md_ack_busy_i & (~fifo_full | pop) & ~flush_i;
   assign {win_found, win_id} = rr_pick(lane_req_valid_i, rr_q);
   assign grant_any = can_issue & win_found;

   // A flush in the pop cycle also suppresses that result.
   assign ack_ok = pop & ~head_discard & ~flush_i;

   always_comb begin
      lane_req_grant_o = '0;
      lane_ack_valid_o = '0;
      sel_ctl          = '0;
      md_req_pc_o      = '0;
      md_req_op0_o     = '0;
      md_req_op1_o     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_any && (win_id == LANE_ID_W'(i))) begin
            lane_req_grant_o[i] = 1'b1;
            sel_ctl.para        = lane_req_para_i[PARA_W*i +: PARA_W];
            sel_ctl.imm         = lane_req_imm_i[IMM_W*i +: IMM_W];
            md_req_pc_o         = lane_req_pc_i[XLEN*i +: XLEN];
            md_req_op0_o        = lane_req_op0_i[XLEN*i +: XLEN];
            md_req_op1_o        = lane_req_op1_i[XLEN*i +: XLEN];
         end
         if (ack_ok && (head_id == LANE_ID_W'(i))) lane_ack_valid_o[i] = 1'b1;
      end
   end

   assign md_req_valid_o  = grant_any;
   assign md_req_para_o   = sel_ctl.para;
   assign md_req_imm_o    = sel_ctl.imm;
   assign lane_ack_data_o = ack_ok ? md_ack_data_i : '0;
   assign arb_err_o       = arb_err_q;

   always_comb begin
      rr_d = rr_q;
      if (grant_any) rr_d = (win_id == LANE_ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
      arb_err_d = arb_err_q | (md_ack_valid_i & fifo_empty);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rr_q      <= '0;
         arb_err_q <= 1'b0;
      end else begin
         rr_q      <= rr_d;
         arb_err_q <= arb_err_d;
      end
   end

endmodule

// File: tb/tb_rv3n_muldiv_arbiter.sv
module tb_rv3n_muldiv_arbiter;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam logic [7:0] OP_MUL = 8'h01;
   localparam logic [7:0] OP_DIV = 8'h04;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [NREQ-1:0]      lane_req_valid;
   logic [NREQ*8-1:0]    lane_req_para;
   logic [NREQ*13-1:0]   lane_req_imm;
   logic [NREQ*XLEN-1:0] lane_req_pc;
   logic [NREQ*XLEN-1:0] lane_req_op0;
   logic [NREQ*XLEN-1:0] lane_req_op1;
   logic [NREQ-1:0]      lane_req_grant;
   logic [NREQ-1:0]      lane_ack_valid;
   logic [XLEN-1:0]      lane_ack_data;
   logic                 md_req_valid;
   logic [7:0]           md_req_para;
   logic [12:0]          md_req_imm;
   logic [XLEN-1:0]      md_req_pc;
   logic [XLEN-1:0]      md_req_op0;
   logic [XLEN-1:0]      md_req_op1;
   logic                 md_ack_valid;
   logic [XLEN-1:0]      md_ack_data;
   logic                 md_ack_busy;
   logic                 arb_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int              lane;
      logic [XLEN-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   rv3n_muldiv_arbiter #(.NREQ(NREQ), .OWN_DEPTH(2), .XLEN(XLEN)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .lane_req_valid_i (lane_req_valid),
      .lane_req_para_i  (lane_req_para),
      .lane_req_imm_i   (lane_req_imm),
      .lane_req_pc_i    (lane_req_pc),
      .lane_req_op0_i   (lane_req_op0),
      .lane_req_op1_i   (lane_req_op1),
      .lane_req_grant_o (lane_req_grant),
      .lane_ack_valid_o (lane_ack_valid),
      .lane_ack_data_o  (lane_ack_data),
      .md_req_valid_o   (md_req_valid),
      .md_req_para_o    (md_req_para),
      .md_req_imm_o     (md_req_imm),
      .md_req_pc_o      (md_req_pc),
      .md_req_op0_o     (md_req_op0),
      .md_req_op1_o     (md_req_op1),
      .md_ack_valid_i   (md_ack_valid),
      .md_ack_data_i    (md_ack_data),
      .md_ack_busy_i    (md_ack_busy),
      .arb_err_o        (arb_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic set_lane(input int l, input logic v, input logic [7:0] para,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      lane_req_valid[l]          = v;
      lane_req_para[8*l +: 8]    = para;
      lane_req_imm[13*l +: 13]   = 13'(l + 1);
      lane_req_pc[XLEN*l +: XLEN]  = 32'h100 + 32'(4 * l);
      lane_req_op0[XLEN*l +: XLEN] = a;
      lane_req_op1[XLEN*l +: XLEN] = b;
   endtask

   task automatic ack(input logic [XLEN-1:0] d, input int lane, input bit expect_it);
      md_ack_valid = 1'b1;
      md_ack_data  = d;
      if (expect_it) exp_q.push_back('{lane: lane, data: d});
   endtask

   // Monitor: every result the DUT presents is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (|lane_ack_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual lane_ack_valid=%b data=%0d required none",
                        lane_ack_valid, lane_ack_data);
            end else begin
               e = exp_q.pop_front();
               chk("sb_lane", 64'(lane_ack_valid), 64'(1 << e.lane));
               chk("sb_data", 64'(lane_ack_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; flush = 1'b0;
      lane_req_valid = '0; lane_req_para = '0; lane_req_imm = '0;
      lane_req_pc = '0; lane_req_op0 = '0; lane_req_op1 = '0;
      md_ack_valid = 1'b0; md_ack_data = '0; md_ack_busy = 1'b0;

      // Reset state
      repeat (2) nxt();
      neg();
      chk("rst_arb_err", 64'(arb_err), 0);
      chk("rst_grant", 64'(lane_req_grant), 0);
      chk("rst_md_valid", 64'(md_req_valid), 0);
      chk("rst_ack_valid", 64'(lane_ack_valid), 0);
      chk("rst_count", 64'(dut.u_fifo.count_o), 0);
      nxt();
      rst = 1'b1;
      nxt();

      // 1: single MUL 3*5 on lane 0
      set_lane(0, 1'b1, OP_MUL, 3, 5);
      neg();
      chk("t1_grant", 64'(lane_req_grant), 64'b01);
      chk("t1_md_valid", 64'(md_req_valid), 1);
      chk("t1_md_para", 64'(md_req_para), 64'(OP_MUL));
      chk("t1_md_imm", 64'(md_req_imm), 1);
      chk("t1_md_op0", 64'(md_req_op0), 3);
      chk("t1_md_op1", 64'(md_req_op1), 5);
      nxt();
      set_lane(0, 1'b0, 8'h00, 0, 0);
      md_ack_busy = 1'b1;
      neg();
      chk("t1_count1", 64'(dut.u_fifo.count_o), 1);
      chk("t1_idle_para", 64'(md_req_para), 0);
      nxt();
      md_ack_busy = 1'b0;
      ack(15, 0, 1'b1);
      nxt();
      md_ack_valid = 1'b0;
      neg();
      chk("t1_count0", 64'(dut.u_fifo.count_o), 0);
      nxt();

      // 2 + 5: alternating grants, pop and grant together at full
      rst = 1'b0; nxt(); rst = 1'b1;
      set_lane(0, 1'b1, OP_MUL, 2, 3);
      set_lane(1, 1'b1, OP_MUL, 4, 5);
      neg();
      chk("t2_grant_a", 64'(lane_req_grant), 64'b01);
      chk("t2_op0_a", 64'(md_req_op0), 2);
      nxt();
      set_lane(0, 1'b1, OP_MUL, 6, 7);
      neg();
      chk("t2_grant_b", 64'(lane_req_grant), 64'b10);
      chk("t2_op0_b", 64'(md_req_op0), 4);
      nxt();
      set_lane(1, 1'b1, OP_MUL, 8, 9);
      neg();
      chk("t2_full_nogrant", 64'(lane_req_grant), 0);
      chk("t2_count_full", 64'(dut.u_fifo.count_o), 2);
      nxt();
      ack(6, 0, 1'b1);
      neg();
      chk("t5_grant_c", 64'(lane_req_grant), 64'b01);
      chk("t5_op0_c", 64'(md_req_op0), 6);
      nxt();
      set_lane(0, 1'b0, 8'h00, 0, 0);
      ack(20, 1, 1'b1);
      neg();
      chk("t5_count_hold", 64'(dut.u_fifo.count_o), 2);
      chk("t5_grant_d", 64'(lane_req_grant), 64'b10);
      chk("t5_op0_d", 64'(md_req_op0), 8);
      nxt();
      set_lane(1, 1'b0, 8'h00, 0, 0);
      ack(42, 0, 1'b1);
      neg();
      chk("t2_nogrant_e", 64'(lane_req_grant), 0);
      nxt();
      ack(72, 1, 1'b1);
      nxt();
      md_ack_valid = 1'b0;
      neg();
      chk("t2_count0", 64'(dut.u_fifo.count_o), 0);
      nxt();

      // 3: DIV 100/7 busy blocks lane 1 until busy drops
      set_lane(0, 1'b1, OP_DIV, 100, 7);
      neg();
      chk("t3_grant_div", 64'(lane_req_grant), 64'b01);
      nxt();
      set_lane(0, 1'b0, 8'h00, 0, 0);
      set_lane(1, 1'b1, OP_MUL, 6, 7);
      md_ack_busy = 1'b1;
      neg();
      chk("t3_busy_nogrant1", 64'(lane_req_grant), 0);
      nxt();
      neg();
      chk("t3_busy_nogrant2", 64'(md_req_valid), 0);
      nxt();
      md_ack_busy = 1'b0;
      ack(14, 0, 1'b1);
      neg();
      chk("t3_grant_l1", 64'(lane_req_grant), 64'b10);
      chk("t3_op0_l1", 64'(md_req_op0), 6);
      nxt();
      set_lane(1, 1'b0, 8'h00, 0, 0);
      md_ack_valid = 1'b0;
      md_ack_busy = 1'b1;
      nxt();
      md_ack_busy = 1'b0;
      ack(42, 1, 1'b1);
      nxt();
      md_ack_valid = 1'b0;

      // 4: flush during in-flight DIV
      set_lane(0, 1'b1, OP_DIV, 50, 5);
      neg();
      chk("t4_grant_div", 64'(lane_req_grant), 64'b01);
      nxt();
      set_lane(0, 1'b0, 8'h00, 0, 0);
      md_ack_busy = 1'b1;
      nxt();
      set_lane(1, 1'b1, OP_MUL, 1, 1);
      md_ack_busy = 1'b0;
      flush = 1'b1;
      neg();
      chk("t4_flush_nogrant", 64'(lane_req_grant), 0);
      nxt();
      flush = 1'b0;
      set_lane(1, 1'b0, 8'h00, 0, 0);
      md_ack_busy = 1'b1;
      nxt();
      md_ack_busy = 1'b0;
      ack(10, 0, 1'b0);
      neg();
      chk("t4_ack_dropped", 64'(lane_ack_valid), 0);
      chk("t4_data_zero", 64'(lane_ack_data), 0);
      nxt();
      md_ack_valid = 1'b0;
      neg();
      chk("t4_count0", 64'(dut.u_fifo.count_o), 0);
      nxt();

      // 4b: flush in the same cycle as the ack
      set_lane(0, 1'b1, OP_MUL, 2, 2);
      neg();
      chk("t4b_grant", 64'(lane_req_grant), 64'b01);
      nxt();
      set_lane(0, 1'b0, 8'h00, 0, 0);
      ack(4, 0, 1'b0);
      flush = 1'b1;
      neg();
      chk("t4b_ack_dropped", 64'(lane_ack_valid), 0);
      nxt();
      md_ack_valid = 1'b0;
      flush = 1'b0;
      neg();
      chk("t4b_count0", 64'(dut.u_fifo.count_o), 0);
      chk("t4b_no_err", 64'(arb_err), 0);
      nxt();

      // 6: ack with empty FIFO raises sticky error
      ack(5, 0, 1'b0);
      neg();
      chk("t6_no_lane_ack", 64'(lane_ack_valid), 0);
      nxt();
      md_ack_valid = 1'b0;
      neg();
      chk("t6_err_set", 64'(arb_err), 1);
      nxt();
      neg();
      chk("t6_err_sticky", 64'(arb_err), 1);
      chk("t6_count0", 64'(dut.u_fifo.count_o), 0);
      nxt();
      rst = 1'b0;
      nxt();
      neg();
      chk("t6_err_cleared", 64'(arb_err), 0);
      rst = 1'b1;
      nxt();
      nxt();

      chk("sb_drain", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
